// File: rtl/display_scan_sched.sv
// Scan sequencer for the dual 7-segment display: digit scan, per-digit blanking and
// tear-free double-buffered commit of time/temperature values. Optional blink: DISP_BLINK_EN.
module display_scan_sched #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] t_data,
  input  logic        t_valid,
  output logic        t_ready,
  input  logic [15:0] c_data,
  input  logic        c_valid,
  output logic        c_ready,
  input  logic        blink_req,
  output logic [11:0] tLED_out,
  output logic [15:0] cLED_out,
  output logic [1:0]  digit,
  output logic        blank,
  output logic        frame_start
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {WAIT_DATA, RUN} top_state_t;
  typedef enum logic {EMPTY, FULL} buf_state_t;

  top_state_t    r_top;
  buf_state_t    r_t_st;
  buf_state_t    r_c_st;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_digit;
  logic          r_frame_start;
  logic [11:0]   r_t_buf;
  logic [15:0]   r_c_buf;
  logic [11:0]   r_tled;
  logic [15:0]   r_cled;

  logic w_tick;
  logic w_frame_bnd;
  logic w_t_cap;
  logic w_c_cap;
  logic w_commit_ok;
  logic w_t_commit;
  logic w_c_commit;
  logic w_blink_blank;

  assign w_tick      = (r_presc == PW'(SCAN_DIV - 1));
  assign w_frame_bnd = w_tick && (r_digit == 2'd3);
  assign w_t_cap     = t_valid && (r_t_st == EMPTY);
  assign w_c_cap     = c_valid && (r_c_st == EMPTY);
  // Before the first commit both values must be present so the display never shows half a pair.
  assign w_commit_ok = w_frame_bnd &&
                       ((r_top == RUN) || ((r_t_st == FULL) && (r_c_st == FULL)));
  assign w_t_commit  = w_commit_ok && (r_t_st == FULL);
  assign w_c_commit  = w_commit_ok && (r_c_st == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc       <= '0;
      r_digit       <= 2'd0;
      r_frame_start <= 1'b0;
      r_top         <= WAIT_DATA;
      r_t_st        <= EMPTY;
      r_c_st        <= EMPTY;
      r_tled        <= '0;
      r_cled        <= '0;
    end else begin
      r_presc       <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick)
        r_digit <= r_digit + 2'd1;
      r_frame_start <= w_frame_bnd;
      if (w_commit_ok)
        r_top <= RUN;

      if (w_t_commit) begin
        r_tled <= r_t_buf;
        r_t_st <= EMPTY;
      end else if (w_t_cap) begin
        r_t_st <= FULL;
      end

      if (w_c_commit) begin
        r_cled <= r_c_buf;
        r_c_st <= EMPTY;
      end else if (w_c_cap) begin
        r_c_st <= FULL;
      end
    end
  end

  // Pending data needs no reset: it is only observable through the FULL flag.
  always_ff @(posedge clk) begin
    if (w_t_cap)
      r_t_buf <= t_data;
    if (w_c_cap)
      r_c_buf <= c_data;
  end

`ifdef DISP_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_bnd) begin
      if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_blink_blank = blink_req && r_blink_phase;
`else
  logic w_unused_blink;
  assign w_unused_blink = blink_req;
  assign w_blink_blank  = 1'b0;
`endif

  assign t_ready     = (r_t_st == EMPTY);
  assign c_ready     = (r_c_st == EMPTY);
  assign tLED_out    = r_tled;
  assign cLED_out    = r_cled;
  assign digit       = r_digit;
  assign frame_start = r_frame_start;
  assign blank       = (r_top == WAIT_DATA) || (r_presc < PW'(BLANK_CYCLES)) || w_blink_blank;

endmodule

// File: tb/tb_display_scan_sched.sv
// Bench for display_scan_sched: cycle-count based reference model checked every cycle,
// plus directed literal checks for each scenario.
module tb_display_scan_sched;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = 4 * SD;
`ifdef DISP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] t_data = '0;
  logic        t_valid = 1'b0;
  logic        t_ready;
  logic [15:0] c_data = '0;
  logic        c_valid = 1'b0;
  logic        c_ready;
  logic        blink_req = 1'b0;
  logic [11:0] tLED_out;
  logic [15:0] cLED_out;
  logic [1:0]  digit;
  logic        blank;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  display_scan_sched #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset),
    .t_data(t_data), .t_valid(t_valid), .t_ready(t_ready),
    .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .blink_req(blink_req),
    .tLED_out(tLED_out), .cLED_out(cLED_out),
    .digit(digit), .blank(blank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset release gives scan position; buffers as simple flags.
  int          m_cyc    = 0;
  bit          m_run    = 1'b0;
  bit          m_t_full = 1'b0;
  bit          m_c_full = 1'b0;
  logic [11:0] m_t_val  = '0;
  logic [15:0] m_c_val  = '0;
  logic [11:0] m_tled   = '0;
  logic [15:0] m_cled   = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc = 0; m_run = 1'b0; m_t_full = 1'b0; m_c_full = 1'b0;
      m_tled = '0; m_cled = '0;
    end else begin
      bit bnd, ok, t_cap, c_cap;
      bnd   = (m_cyc % FRAME) == FRAME - 1;
      ok    = bnd && (m_run || (m_t_full && m_c_full));
      t_cap = t_valid && !m_t_full;
      c_cap = c_valid && !m_c_full;
      if (ok) begin
        m_run = 1'b1;
        if (m_t_full) begin m_tled = m_t_val; m_t_full = 1'b0; end
        if (m_c_full) begin m_cled = m_c_val; m_c_full = 1'b0; end
      end
      if (t_cap) begin m_t_val = t_data; m_t_full = 1'b1; end
      if (c_cap) begin m_c_val = c_data; m_c_full = 1'b1; end
      m_cyc = m_cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, m_cyc, $time);
    end
  endtask

  always @(negedge clk) begin
    int  presc;
    bit  phase;
    bit  exp_blank;
    presc     = m_cyc % SD;
    phase     = ((m_cyc / FRAME) / BF) % 2 == 1;
    exp_blank = !m_run || (presc < BC) || (BLINK && blink_req && phase);
    chk("m_digit",  {30'd0, digit},       (m_cyc / SD) % 4);
    chk("m_fstart", {31'd0, frame_start}, (m_cyc != 0 && m_cyc % FRAME == 0) ? 1 : 0);
    chk("m_blank",  {31'd0, blank},       {31'd0, exp_blank});
    chk("m_tready", {31'd0, t_ready},     {31'd0, !m_t_full});
    chk("m_cready", {31'd0, c_ready},     {31'd0, !m_c_full});
    chk("m_tled",   {20'd0, tLED_out},    {20'd0, m_tled});
    chk("m_cled",   {16'd0, cLED_out},    {16'd0, m_cled});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto_cyc(input int c);
    step(c - cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    t_valid = 1'b0; c_valid = 1'b0; blink_req = 1'b0;
    step(2);
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Idle after reset: scan runs, display stays blank, nothing commits.
    do_reset();
    chk("rst_blank", {31'd0, blank}, 1);
    chk("rst_tready", {31'd0, t_ready}, 1);
    goto_cyc(8);
    chk("idle_digit1", {30'd0, digit}, 1);
    goto_cyc(32);
    chk("idle_fstart", {31'd0, frame_start}, 1);
    chk("idle_digit0", {30'd0, digit}, 0);
    goto_cyc(33);
    chk("idle_fstart_low", {31'd0, frame_start}, 0);
    goto_cyc(70);
    chk("idle_tled", {20'd0, tLED_out}, 0);

    // First pair of values commits at the first frame boundary and enters RUN.
    do_reset();
    goto_cyc(5);
    t_data = 12'h123; c_data = 16'h0250; t_valid = 1'b1; c_valid = 1'b1;
    goto_cyc(6);
    t_valid = 1'b0; c_valid = 1'b0;
    chk("cap_tready", {31'd0, t_ready}, 0);
    chk("cap_cready", {31'd0, c_ready}, 0);
    goto_cyc(31);
    chk("pre_commit_tled", {20'd0, tLED_out}, 0);
    goto_cyc(32);
    chk("commit_tled", {20'd0, tLED_out}, 12'h123);
    chk("commit_cled", {16'd0, cLED_out}, 16'h0250);
    chk("commit_tready", {31'd0, t_ready}, 1);
    chk("run_blank_p0", {31'd0, blank}, 1);
    goto_cyc(34);
    chk("run_blank_p2", {31'd0, blank}, 0);

    // Back-to-back pushes in one frame: second is held until the buffer frees.
    goto_cyc(40);
    t_data = 12'h045; t_valid = 1'b1;
    goto_cyc(41);
    t_data = 12'h044;
    chk("hold_tready", {31'd0, t_ready}, 0);
    goto_cyc(64);
    chk("hold_tled_045", {20'd0, tLED_out}, 12'h045);
    chk("hold_tready_back", {31'd0, t_ready}, 1);
    goto_cyc(65);
    t_valid = 1'b0;
    chk("hold_tready_again", {31'd0, t_ready}, 0);
    goto_cyc(95);
    chk("hold_tled_still", {20'd0, tLED_out}, 12'h045);
    goto_cyc(96);
    chk("hold_tled_044", {20'd0, tLED_out}, 12'h044);

    // Only temperature supplied: stays waiting until time arrives too.
    do_reset();
    goto_cyc(3);
    c_data = 16'h1111; c_valid = 1'b1;
    goto_cyc(4);
    c_valid = 1'b0;
    goto_cyc(100);
    chk("wait_cready", {31'd0, c_ready}, 0);
    chk("wait_cled", {16'd0, cLED_out}, 0);
    chk("wait_blank", {31'd0, blank}, 1);
    t_data = 12'h222; t_valid = 1'b1;
    goto_cyc(101);
    t_valid = 1'b0;
    goto_cyc(128);
    chk("both_tled", {20'd0, tLED_out}, 12'h222);
    chk("both_cled", {16'd0, cLED_out}, 16'h1111);

    // Reset mid-frame with a pending value: everything clears immediately.
    goto_cyc(140);
    t_data = 12'h999; t_valid = 1'b1;
    goto_cyc(141);
    t_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_tled", {20'd0, tLED_out}, 0);
    chk("arst_cled", {16'd0, cLED_out}, 0);
    chk("arst_blank", {31'd0, blank}, 1);
    chk("arst_digit", {30'd0, digit}, 0);
    chk("arst_tready", {31'd0, t_ready}, 1);
    do_reset();
    goto_cyc(40);
    chk("arst_no_ghost", {20'd0, tLED_out}, 0);

    // Blink behaviour (only effective with the blink build).
    do_reset();
    goto_cyc(2);
    t_data = 12'h321; c_data = 16'h0180; t_valid = 1'b1; c_valid = 1'b1;
    goto_cyc(3);
    t_valid = 1'b0; c_valid = 1'b0;
    blink_req = 1'b1;
    goto_cyc(44);
    chk("blink_ph0", {31'd0, blank}, 0);
    goto_cyc(70);
    chk("blink_ph1", {31'd0, blank}, BLINK ? 1 : 0);
    goto_cyc(134);
    chk("blink_ph0b", {31'd0, blank}, 0);
    goto_cyc(198);
    chk("blink_ph1b", {31'd0, blank}, BLINK ? 1 : 0);
    blink_req = 1'b0;
    goto_cyc(230);
    chk("blink_off", {31'd0, blank}, 0);
    goto_cyc(260);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/display_scan_sched.md
Name: display_scan_sched

Overview:
- Sequencing controller for the toaster's dual 7-segment display datapath (time and temperature digit muxes).
- Generates the 2-bit scan digit index at a fixed refresh rate.
- Accepts new time/temperature values from producers via valid/ready handshakes and double-buffers them.
- Commits new values only at frame boundaries (no tearing) and emits per-digit anti-ghosting blanking.

Parameters:
SCAN_DIV, 50000, clk cycles per digit period (>= 4)
BLANK_CYCLES, 500, blanking cycles at start of each digit period (< SCAN_DIV)
BLINK_FRAMES, 125, frames per blink half-period (DISP_BLINK_EN only, >= 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
t_data  input  12  time value (3 BCD digits)
t_valid  input  1  t_data valid
t_ready  output  1  time pending buffer can accept
c_data  input  16  temperature value (4 BCD digits)
c_valid  input  1  c_data valid
c_ready  output  1  temperature pending buffer can accept
blink_req  input  1  request blinking display
tLED_out  output  12  committed time value to digit mux
cLED_out  output  16  committed temperature value to digit mux
digit  output  2  current scan digit 0..3
blank  output  1  1 = all digit enables off
frame_start  output  1  one-cycle pulse, first cycle of digit 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high.
- Reset values: tLED_out=0, cLED_out=0, digit=0, blank=1, frame_start=0, t_ready=1, c_ready=1. Prescaler, frame counter and blink phase are 0. Pending buffers are EMPTY. Top FSM is WAIT_DATA.
- Reset mid-operation: discards pending data and committed values immediately (asynchronous).
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. tick = (prescaler==SCAN_DIV-1).
- Digit advance: on tick, digit <= digit+1 mod 4.
- Frame boundary: a tick with digit==3.
- frame_start: registered pulse, high for the single cycle after a frame boundary (digit==0, prescaler==0). It also pulses in WAIT_DATA.
- Pending buffers (t and c independent), each a 2-state FSM, EMPTY/FULL:
  - ready = (state==EMPTY).
  - valid&&ready: capture data, go FULL.
  - FULL at frame boundary in RUN: copy to tLED_out/cLED_out, go EMPTY.
  - valid while FULL: not accepted; producer holds data (no drop).
  - A new capture is impossible in the commit cycle (ready=0). ready returns high the cycle after commit.
- Top FSM:
  - WAIT_DATA: blank forced 1; no commits occur. At a frame boundary with both buffers FULL, commit both and go to RUN.
  - RUN: committed outputs change only at frame boundaries; each buffer commits independently. RUN persists until reset.
- Blank in RUN: blank=1 when prescaler < BLANK_CYCLES, else 0 (combinational from registered counter).
- Latency: data accepted in frame N appears on outputs at the end of frame N (at most one frame).

Optional Feature:
- Macro: DISP_BLINK_EN.
- Defined:
  - A frame counter 0..BLINK_FRAMES-1 advances on each frame boundary.
  - blink_phase toggles on each frame-counter wrap.
  - In RUN, blink_req=1 and blink_phase=1 forces blank=1 for the whole frame.
  - blink_req is sampled per cycle; counter and phase free-run regardless of blink_req.
- Undefined: blink_req is ignored, and no frame counter or phase logic is present.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2):
- Reset release, no data -> digit steps 0,1,2,3 every 8 cycles; blank=1 throughout; t_ready=c_ready=1; frame_start pulses every 32 cycles; outputs 0.
- t_data=12'h123 and c_data=16'h0250 each pulsed valid at cycle 5 -> ready drops next cycle; at first frame boundary outputs become 123/0250; FSM enters RUN; then blank=1 only for prescaler 0-1 of each digit; ready high again.
- In RUN, push t=12'h045, then attempt t=12'h044 in same frame -> second held with t_ready=0; tLED_out=045 after boundary; 044 accepted next cycle and commits one frame later.
- Only c pushed after reset -> remains WAIT_DATA, blank=1, c_ready=0 indefinitely; then push t -> both commit at next boundary.
- Assert reset mid-frame in RUN with pending t FULL -> outputs 0, blank=1, digit=0, ready=1 immediately; pending value never appears.
- DISP_BLINK_EN, RUN, blink_req=1 -> blank alternates: 2 frames normal pattern, 2 frames solid 1. blink_req=0 -> normal pattern only. Without the macro, blink_req has no effect.
